// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor: processes BPC bits per clock through a ripple
// slice until WIDTH bits are done, then reports result, carry and overflow.
module serial_addsub_n #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NSTEP = WIDTH / BPC;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  generate
    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
      $error("serial_addsub_n: WIDTH must be >= 2 and divisible by BPC");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, new_sum;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, finish;
  logic [BPC:0]     ch;
  logic [BPC-1:0]   s;

  // Ripple chain across the BPC low bits of the shifting operands.
  always_comb begin
    ch    = '0;
    s     = '0;
    ch[0] = carry;
    for (int i = 0; i < BPC; i++) begin
      s[i]    = a_reg[i] ^ b_reg[i] ^ ch[i];
      ch[i+1] = (a_reg[i] & b_reg[i]) | (ch[i] & (a_reg[i] ^ b_reg[i]));
    end
  end

  // Sum bits enter from the top so the LSB chunk ends up at bit 0.
  generate
    if (BPC == WIDTH) begin : g_full
      assign new_sum = s;
    end else begin : g_shift
      assign new_sum = {s, sum_reg[WIDTH-1:BPC]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        next_state = RUN;
      end
      RUN: if (cnt == LAST) begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: datapath registers are all cleared on reset so an aborted operation
  // leaves no stale operand or partial sum behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      c       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= sub ? ~b : b;
        carry   <= sub;
        sum_reg <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_reg   <= a_reg >> BPC;
        b_reg   <= b_reg >> BPC;
        sum_reg <= new_sum;
        carry   <= ch[BPC];
        cnt     <= cnt + 1'b1;
        if (finish) begin
          // ch[BPC-1] is the carry into the MSB on the last step.
          c    <= new_sum;
          cout <= ch[BPC];
          ovf  <= ch[BPC-1] ^ ch[BPC];
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule
